pipeline_sequencer: RTL and testbench

//  Hazard, stall and halt sequencer for the 5-stage pipelined CPU. It sits beside the main decoder in ID.
//  It drives the PC write enable, IF/ID and ID/EX register enables/flushes, and the global enable for EX/MEM/WB.
//  It inserts load-use, flag and branch-register bubbles, flushes on taken branches, freezes on memory busy,
//  and drains the pipe on HALT before asserting halted.

---
 rtl/pipeline_sequencer_if.sv | 42 ++++
 rtl/pipeline_sequencer.sv | 129 ++++++++++++
 tb/tb_pipeline_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_sequencer_if : ID-stage hazard inputs and pipe control      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pipeline_sequencer_if;
   logic       id_valid;
   logic [3:0] id_opcode;
   logic [3:0] id_rs;
   logic [3:0] id_rt;
   logic       id_uses_rs;
   logic       id_uses_rt;
   logic       id_branch_taken;
   logic       ex_memread;
   logic       ex_regwrite;
   logic [3:0] ex_rd;
   logic [2:0] ex_setflags;
   logic       mem_regwrite;
   logic [3:0] mem_rd;
   logic       imem_busy;
   logic       dmem_busy;
   logic       pc_we;
   logic       ifid_we;
   logic       ifid_flush;
   logic       idex_flush;
   logic       pipe_en;

   modport master (
      output id_valid, id_opcode, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_branch_taken, ex_memread, ex_regwrite, ex_rd, ex_setflags,
             mem_regwrite, mem_rd, imem_busy, dmem_busy,
      input  pc_we, ifid_we, ifid_flush, idex_flush, pipe_en
   );

   modport slave (
      input  id_valid, id_opcode, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_branch_taken, ex_memread, ex_regwrite, ex_rd, ex_setflags,
             mem_regwrite, mem_rd, imem_busy, dmem_busy,
      output pc_we, ifid_we, ifid_flush, idex_flush, pipe_en
   );
endinterface
`default_nettype wire

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_sequencer : hazard/stall/halt sequencer for the 5-stage CPU |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipeline_sequencer #(
   parameter int DRAIN_CYCLES = 3,
   parameter int PERF_W       = 16
) (
   input  logic                clk,
   input  logic                rst,
   pipeline_sequencer_if.slave bus,
   output logic                halted,
   output logic [PERF_W-1:0]   stall_count
);
   localparam int         c_CNT_W   = $clog2(DRAIN_CYCLES + 1);
   localparam logic [3:0] c_OP_B    = 4'hC;
   localparam logic [3:0] c_OP_BR   = 4'hD;
   localparam logic [3:0] c_OP_HALT = 4'hF;

   localparam logic [1:0] c_ST_RUN    = 2'd0;
   localparam logic [1:0] c_ST_DRAIN  = 2'd1;
   localparam logic [1:0] c_ST_HALTED = 2'd2;

   logic [1:0]         r_state;
   logic [c_CNT_W-1:0] r_drain;
   logic               r_halted;
   logic [PERF_W-1:0]  r_stall_count;

   logic [1:0]         w_nxt_state;
   logic [c_CNT_W-1:0] w_nxt_drain;
   logic               w_count_stall;
   logic               w_load_use;
   logic               w_flag_haz;
   logic               w_br_haz;
   logic               w_hazard;
   logic               w_busy;
   logic               w_halt_id;

   // r0 is hardwired zero, so a match on it is never a real dependency
   assign w_load_use = bus.id_valid & bus.ex_memread & (bus.ex_rd != 4'd0) &
                       ((bus.id_uses_rs & (bus.id_rs == bus.ex_rd)) |
                        (bus.id_uses_rt & (bus.id_rt == bus.ex_rd)));
   assign w_flag_haz = bus.id_valid & ((bus.id_opcode == c_OP_B) | (bus.id_opcode == c_OP_BR)) &
                       (bus.ex_setflags != 3'd0);
   assign w_br_haz   = bus.id_valid & (bus.id_opcode == c_OP_BR) & (bus.id_rs != 4'd0) &
                       ((bus.ex_regwrite & (bus.ex_rd == bus.id_rs)) |
                        (bus.mem_regwrite & (bus.mem_rd == bus.id_rs)));
   assign w_hazard   = w_load_use | w_flag_haz | w_br_haz;
   assign w_busy     = bus.imem_busy | bus.dmem_busy;
   assign w_halt_id  = bus.id_valid & (bus.id_opcode == c_OP_HALT);

   always_comb begin
      bus.pc_we      = 1'b0;
      bus.ifid_we    = 1'b0;
      bus.ifid_flush = 1'b0;
      bus.idex_flush = 1'b0;
      bus.pipe_en    = 1'b0;
      w_nxt_state    = r_state;
      w_nxt_drain    = r_drain;
      w_count_stall  = 1'b0;
      if (rst) begin
         bus.ifid_flush = 1'b1;
         bus.idex_flush = 1'b1;
      end else begin
         case (r_state)
            c_ST_RUN: begin
               if (w_busy) begin
                  w_count_stall = 1'b1;
               end else if (w_hazard) begin
                  w_count_stall  = 1'b1;
                  bus.idex_flush = 1'b1;
                  bus.pipe_en    = 1'b1;
               end else if (w_halt_id) begin
                  // HALT advances into EX as a no-op while IF/ID is bubbled behind it
                  bus.ifid_we    = 1'b1;
                  bus.ifid_flush = 1'b1;
                  bus.pipe_en    = 1'b1;
                  w_nxt_drain    = c_CNT_W'(DRAIN_CYCLES);
                  w_nxt_state    = c_ST_DRAIN;
               end else if (bus.id_branch_taken) begin
                  bus.pc_we      = 1'b1;
                  bus.ifid_we    = 1'b1;
                  bus.ifid_flush = 1'b1;
                  bus.pipe_en    = 1'b1;
               end else begin
                  bus.pc_we      = 1'b1;
                  bus.ifid_we    = 1'b1;
                  bus.pipe_en    = 1'b1;
               end
            end
            c_ST_DRAIN: begin
               if (!w_busy) begin
                  bus.ifid_flush = 1'b1;
                  bus.idex_flush = 1'b1;
                  bus.pipe_en    = 1'b1;
                  w_nxt_drain    = r_drain - c_CNT_W'(1);
                  if (r_drain == c_CNT_W'(1)) begin
                     w_nxt_state = c_ST_HALTED;
                  end
               end
            end
            default: begin
               w_nxt_state = c_ST_HALTED;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= c_ST_RUN;
         r_drain       <= '0;
         r_halted      <= 1'b0;
         r_stall_count <= '0;
      end else begin
         r_state  <= w_nxt_state;
         r_drain  <= w_nxt_drain;
         r_halted <= (w_nxt_state == c_ST_HALTED);
         if (w_count_stall && (r_stall_count != {PERF_W{1'b1}})) begin
            r_stall_count <= r_stall_count + PERF_W'(1);
         end
      end
   end

   assign halted      = r_halted;
   assign stall_count = r_stall_count;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipeline_sequencer : directed + random check against a ref model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipeline_sequencer;
   localparam int DRAIN = 3;
   localparam int PW    = 6;
   localparam int SAT   = (1 << PW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          halted;
   logic [PW-1:0] stall_count;

   pipeline_sequencer_if bus ();

   pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .PERF_W(PW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .halted      (halted),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model: cycles of drain left, halted flag, stall tally
   int m_drain_left = 0;
   bit m_halted     = 1'b0;
   int m_stall      = 0;
   bit m_known      = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      rst                 = 1'b0;
      bus.id_valid        = 1'b0;
      bus.id_opcode       = 4'h0;
      bus.id_rs           = 4'h0;
      bus.id_rt           = 4'h0;
      bus.id_uses_rs      = 1'b0;
      bus.id_uses_rt      = 1'b0;
      bus.id_branch_taken = 1'b0;
      bus.ex_memread      = 1'b0;
      bus.ex_regwrite     = 1'b0;
      bus.ex_rd           = 4'h0;
      bus.ex_setflags     = 3'b000;
      bus.mem_regwrite    = 1'b0;
      bus.mem_rd          = 4'h0;
      bus.imem_busy       = 1'b0;
      bus.dmem_busy       = 1'b0;
   endtask

   function automatic bit id_reads(input logic [3:0] r);
      return (r != 4'd0) && ((bus.id_uses_rs && bus.id_rs == r) || (bus.id_uses_rt && bus.id_rt == r));
   endfunction

   function automatic bit reg_pending(input logic [3:0] r);
      return (r != 4'd0) && ((bus.ex_regwrite && bus.ex_rd == r) || (bus.mem_regwrite && bus.mem_rd == r));
   endfunction

   // Called just after a falling edge with inputs already applied; checks, advances model, waits one cycle.
   task automatic cycle();
      bit         busy, haz, is_branch, halt_id;
      logic [4:0] exp;
      #1;
      busy      = bus.imem_busy || bus.dmem_busy;
      is_branch = (bus.id_opcode == 4'hC) || (bus.id_opcode == 4'hD);
      haz       = bus.id_valid && ((bus.ex_memread && id_reads(bus.ex_rd)) ||
                                   (is_branch && bus.ex_setflags != 3'b000) ||
                                   (bus.id_opcode == 4'hD && reg_pending(bus.id_rs)));
      halt_id   = bus.id_valid && bus.id_opcode == 4'hF;
      // expected {pc_we, ifid_we, ifid_flush, idex_flush, pipe_en}
      if (rst)                    exp = 5'b00110;
      else if (m_halted)          exp = 5'b00000;
      else if (m_drain_left > 0)  exp = busy ? 5'b00000 : 5'b00111;
      else if (busy)              exp = 5'b00000;
      else if (haz)               exp = 5'b00011;
      else if (halt_id)           exp = 5'b01101;
      else if (bus.id_branch_taken) exp = 5'b11101;
      else                        exp = 5'b11001;
      check("ctrl", 32'({bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_flush, bus.pipe_en}), 32'(exp));
      if (m_known) begin
         check("halted", 32'(halted), 32'(m_halted));
         check("stall_count", 32'(stall_count), 32'(m_stall));
      end
      if (rst) begin
         m_drain_left = 0;
         m_halted     = 1'b0;
         m_stall      = 0;
         m_known      = 1'b1;
      end else if (m_halted) begin
      end else if (m_drain_left > 0) begin
         if (!busy) begin
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1'b1;
         end
      end else begin
         if ((busy || haz) && m_stall < SAT) m_stall++;
         if (!busy && !haz && halt_id) m_drain_left = DRAIN;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      cycle();
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      @(negedge clk);
      do_reset();
      do_reset();
      cycle();

      // load-use on r3, then clears
      bus.ex_memread = 1'b1; bus.ex_rd = 4'd3;
      bus.id_valid = 1'b1; bus.id_opcode = 4'h1; bus.id_rs = 4'd3; bus.id_uses_rs = 1'b1;
      cycle();
      clear_inputs(); bus.id_valid = 1'b1; bus.id_opcode = 4'h1; bus.id_rs = 4'd3; bus.id_uses_rs = 1'b1;
      cycle();

      // load into r0 is no hazard
      clear_inputs(); bus.ex_memread = 1'b1; bus.ex_rd = 4'd0;
      bus.id_valid = 1'b1; bus.id_rs = 4'd0; bus.id_uses_rs = 1'b1;
      cycle();

      // B waits on flags, then resolves taken
      clear_inputs(); bus.id_valid = 1'b1; bus.id_opcode = 4'hC; bus.ex_setflags = 3'b111;
      cycle();
      clear_inputs(); bus.id_valid = 1'b1; bus.id_opcode = 4'hC; bus.id_branch_taken = 1'b1;
      cycle();

      // BR on r5 with MEM writer, busy first
      clear_inputs(); bus.id_valid = 1'b1; bus.id_opcode = 4'hD; bus.id_rs = 4'd5;
      bus.mem_regwrite = 1'b1; bus.mem_rd = 4'd5; bus.dmem_busy = 1'b1;
      cycle();
      bus.dmem_busy = 1'b0;
      cycle();

      // HALT drain with one busy cycle mid-drain
      clear_inputs(); bus.id_valid = 1'b1; bus.id_opcode = 4'hF;
      cycle();
      clear_inputs();
      cycle();
      bus.imem_busy = 1'b1;
      cycle();
      bus.imem_busy = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      check("halted_after_drain", 32'(halted), 32'd1);

      // reset while halted
      do_reset();
      cycle();
      check("halted_cleared", 32'(halted), 32'd0);

      // saturate the stall counter
      bus.imem_busy = 1'b1;
      for (int i = 0; i < SAT + 4; i++) cycle();
      clear_inputs();
      cycle();
      check("stall_saturated", 32'(stall_count), 32'(SAT));
      do_reset();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         clear_inputs();
         rst                 = ($urandom_range(0, 59) == 0);
         bus.id_valid        = ($urandom_range(0, 7) != 0);
         bus.id_opcode       = 4'($urandom_range(0, 15));
         if (bus.id_opcode == 4'hF && $urandom_range(0, 3) != 0) bus.id_opcode = 4'h2;
         bus.id_rs           = 4'($urandom_range(0, 3));
         bus.id_rt           = 4'($urandom_range(0, 3));
         bus.id_uses_rs      = 1'($urandom_range(0, 1));
         bus.id_uses_rt      = 1'($urandom_range(0, 1));
         bus.id_branch_taken = ($urandom_range(0, 3) == 0);
         bus.ex_memread      = 1'($urandom_range(0, 1));
         bus.ex_regwrite     = 1'($urandom_range(0, 1));
         bus.ex_rd           = 4'($urandom_range(0, 3));
         bus.ex_setflags     = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         bus.mem_regwrite    = 1'($urandom_range(0, 1));
         bus.mem_rd          = 4'($urandom_range(0, 3));
         bus.imem_busy       = ($urandom_range(0, 9) == 0);
         bus.dmem_busy       = ($urandom_range(0, 9) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
